wb_write_queue: RTL and testbench

Writeback queue that owns the write port of the integer register file. It accepts completed results from the ALU and the load unit through valid/ready handshakes. It buffers them in a small in-order FIFO and retires at most one register write per cycle, always from a registered output. It also provides bypass lookups so that readers of the register file see values that are queued or in flight but not yet committed.

---
 rtl/wb_write_queue.sv | 163 ++++++++++++++++
 tb/tb_wb_write_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback queue owning the integer register-file write port: merges ALU and load
// results into an in-order FIFO, retires one registered write per cycle, and serves bypass lookups.
module wb_write_queue #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 5,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,

    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,

    output logic              write_enable,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,

    input  logic [ADDR_W-1:0] byp_addr_1,
    input  logic [ADDR_W-1:0] byp_addr_2,
    output logic              byp_hit_1,
    output logic              byp_hit_2,
    output logic [DATA_W-1:0] byp_data_1,
    output logic [DATA_W-1:0] byp_data_2,

    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] free;
    logic             full_q;
    logic             empty_q;

    logic             alu_acc;
    logic             ld_acc;
    logic             alu_push;
    logic             ld_push;
    logic             pop;
    logic [PTR_W-1:0] ld_slot;

    // Handshake: a source transfers on a rising edge where its valid and ready are both 1.
    // Ready depends only on the registered occupancy (and alu_valid for the load port), never
    // on this cycle's drain, so a full queue cannot accept even while it is popping.
    always_comb begin
        free      = CNT_W'(DEPTH) - count_q;
        alu_ready = reset && (free >= CNT_W'(1));
        ld_ready  = reset && ((free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !alu_valid));
    end

    // Writes to x0 complete the handshake but are dropped before they take a slot.
    always_comb begin
        alu_acc  = alu_valid && alu_ready;
        ld_acc   = ld_valid && ld_ready;
        alu_push = alu_acc && (alu_rd != '0);
        ld_push  = ld_acc && (ld_rd != '0);
        pop      = (count_q != '0);
        ld_slot  = tail_q + PTR_W'(alu_push);
        count_next = count_q + CNT_W'(alu_push) + CNT_W'(ld_push) - CNT_W'(pop);
    end

    // The ALU entry goes in first so it is older than a same-cycle load.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            q_rd[tail_q]   <= alu_rd;
            q_data[tail_q] <= alu_data;
        end
        if (ld_push) begin
            q_rd[ld_slot]   <= ld_rd;
            q_data[ld_slot] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            head_q       <= head_q + PTR_W'(pop);
            tail_q       <= tail_q + PTR_W'(alu_push) + PTR_W'(ld_push);
            count_q      <= count_next;
            full_q       <= (count_next == CNT_W'(DEPTH));
            empty_q      <= (count_next == '0);
            write_enable <= pop;
            if (pop) begin
                write_reg  <= q_rd[head_q];
                write_data <= q_data[head_q];
            end
        end
    end

    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

    // Bypass scans oldest to youngest so a later match overrides an earlier one:
    // the output register first, then the FIFO from head towards tail.
    logic [PTR_W-1:0] scan_idx;

    always_comb begin
        byp_hit_1  = 1'b0;
        byp_hit_2  = 1'b0;
        byp_data_1 = '0;
        byp_data_2 = '0;
        scan_idx   = '0;

        if (write_enable && (write_reg == byp_addr_1)) begin
            byp_hit_1  = 1'b1;
            byp_data_1 = write_data;
        end
        if (write_enable && (write_reg == byp_addr_2)) begin
            byp_hit_2  = 1'b1;
            byp_data_2 = write_data;
        end

        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if (q_rd[scan_idx] == byp_addr_1) begin
                    byp_hit_1  = 1'b1;
                    byp_data_1 = q_data[scan_idx];
                end
                if (q_rd[scan_idx] == byp_addr_2) begin
                    byp_hit_2  = 1'b1;
                    byp_data_2 = q_data[scan_idx];
                end
            end
        end

        // x0 is hardwired; it must never be forwarded.
        if (byp_addr_1 == '0) begin
            byp_hit_1  = 1'b0;
            byp_data_1 = '0;
        end
        if (byp_addr_2 == '0) begin
            byp_hit_2  = 1'b0;
            byp_data_2 = '0;
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: hand-checked scenarios plus an in-order queue
// scoreboard that predicts readiness, retired writes, occupancy and bypass.
module tb_wb_write_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ENT_W  = ADDR_W + DATA_W;

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              write_enable;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] byp_addr_1;
    logic [ADDR_W-1:0] byp_addr_2;
    logic              byp_hit_1;
    logic              byp_hit_2;
    logic [DATA_W-1:0] byp_data_1;
    logic [DATA_W-1:0] byp_data_2;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .byp_addr_1   (byp_addr_1),
        .byp_addr_2   (byp_addr_2),
        .byp_hit_1    (byp_hit_1),
        .byp_hit_2    (byp_hit_2),
        .byp_data_1   (byp_data_1),
        .byp_data_2   (byp_data_2),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: queued entries {rd, data} plus the predicted output register
    logic [ENT_W-1:0]  exp_q[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    // One cycle: drive both sources, check readies, advance model, check registered results.
    task automatic drive_cycle(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                               input logic lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ldv);
        int               fr;
        logic             e_ar;
        logic             e_lr;
        logic [ENT_W-1:0] ent;
        logic             e_hit;
        logic [DATA_W-1:0] e_bd;

        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lr;
        ld_data   = ldv;
        #1;
        fr   = DEPTH - exp_q.size();
        e_ar = (fr >= 1);
        e_lr = (fr >= 2) || ((fr >= 1) && !av);
        check("alu_ready", 32'(alu_ready), 32'(e_ar));
        check("ld_ready", 32'(ld_ready), 32'(e_lr));

        if (exp_q.size() > 0) begin
            ent    = exp_q.pop_front();
            m_we   = 1'b1;
            m_rd   = ent[ENT_W-1:DATA_W];
            m_data = ent[DATA_W-1:0];
        end else begin
            m_we = 1'b0;
        end
        if (av && e_ar && (ar != '0)) exp_q.push_back({ar, ad});
        if (lv && e_lr && (lr != '0)) exp_q.push_back({lr, ldv});

        @(posedge clk);
        #1;
        check("write_enable", 32'(write_enable), 32'(m_we));
        check("write_reg", 32'(write_reg), 32'(m_rd));
        check("write_data", write_data, m_data);
        check("count", 32'(count), 32'(exp_q.size()));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));

        e_hit = 1'b0;
        e_bd  = '0;
        if (byp_addr_1 != '0) begin
            if (m_we && (m_rd == byp_addr_1)) begin
                e_hit = 1'b1;
                e_bd  = m_data;
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                ent = exp_q[k];
                if (ent[ENT_W-1:DATA_W] == byp_addr_1) begin
                    e_hit = 1'b1;
                    e_bd  = ent[DATA_W-1:0];
                end
            end
        end
        check("byp_hit_1", 32'(byp_hit_1), 32'(e_hit));
        check("byp_data_1", byp_data_1, e_bd);

        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic idle();
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        reset      = 1'b0;
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        ld_valid   = 1'b0;
        ld_rd      = '0;
        ld_data    = '0;
        byp_addr_1 = 5'd3;
        byp_addr_2 = 5'd0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_byp_hit_1", 32'(byp_hit_1), 32'd0);
        check("rst_byp_data_1", byp_data_1, 32'd0);

        reset = 1'b1;
        #1;
        check("rel_alu_ready", 32'(alu_ready), 32'd1);
        check("rel_ld_ready", 32'(ld_ready), 32'd1);

        // Single push: visible in bypass for two cycles, written on the second
        drive_cycle(1'b1, 5'd3, 32'hA5, 1'b0, '0, '0);
        check("t1_count_1", 32'(count), 32'd1);
        check("t1_we_0", 32'(write_enable), 32'd0);
        check("t1_byp_q", byp_data_1, 32'hA5);
        idle();
        check("t1_we_1", 32'(write_enable), 32'd1);
        check("t1_reg", 32'(write_reg), 32'd3);
        check("t1_data", write_data, 32'hA5);
        check("t1_count_0", 32'(count), 32'd0);
        check("t1_byp_out", byp_data_1, 32'hA5);
        idle();
        check("t1_we_off", 32'(write_enable), 32'd0);
        check("t1_byp_gone", 32'(byp_hit_1), 32'd0);

        // Dual push to the same register: ALU older, load younger
        byp_addr_1 = 5'd5;
        drive_cycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        check("t2_count", 32'(count), 32'd2);
        check("t2_byp_a", byp_data_1, 32'h22);
        idle();
        check("t2_first", write_data, 32'h11);
        check("t2_byp_b", byp_data_1, 32'h22);
        idle();
        check("t2_second", write_data, 32'h22);
        check("t2_byp_c", byp_data_1, 32'h22);
        idle();
        check("t2_byp_gone", 32'(byp_hit_1), 32'd0);

        // x0 filter
        drive_cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0);
        check("t3_count", 32'(count), 32'd0);
        check("t3_byp_hit_2", 32'(byp_hit_2), 32'd0);
        check("t3_byp_data_2", byp_data_2, 32'd0);
        idle();
        check("t3_no_we", 32'(write_enable), 32'd0);

        // Continuous dual-source pressure
        byp_addr_1 = 5'd9;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, ADDR_W'(8 + (i % 4)), 32'h1000 + 32'(i),
                        1'b1, ADDR_W'(9 + (i % 3)), 32'h2000 + 32'(i));
        end
        check("t4_steady_count", 32'(count), 32'd3);
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd9, 32'h2FFF);
        repeat (6) idle();
        check("t4_drained_count", 32'(count), 32'd0);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Mid-operation reset discards everything
        byp_addr_1 = 5'd6;
        drive_cycle(1'b1, 5'd6, 32'h61, 1'b1, 5'd6, 32'h62);
        drive_cycle(1'b1, 5'd6, 32'h63, 1'b1, 5'd6, 32'h64);
        check("t5_filled", 32'(count), 32'd3);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("t5_we", 32'(write_enable), 32'd0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_write_reg", 32'(write_reg), 32'd0);
        check("t5_write_data", write_data, 32'd0);
        check("t5_alu_ready", 32'(alu_ready), 32'd0);
        check("t5_byp_hit", 32'(byp_hit_1), 32'd0);
        reset = 1'b1;
        repeat (4) idle();

        // Streaming single pushes across pointer wrap
        byp_addr_1 = 5'd2;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, ADDR_W'(1 + (i % 5)), 32'h3000 + 32'(i), 1'b0, '0, '0);
            check("t6_count", 32'(count), 32'd1);
        end
        repeat (3) idle();
        check("t6_final_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
